mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline memory stage; sits directly downstream of the execute stage (through the EX/MEM latch) and feeds the writeback register.
- Executes loads and stores over a byte-wide synchronous RAM port, one byte per cycle, little-endian.
- Sign/zero-extends load data and holds the pipeline via stall_req_o until each access completes.
- Passes non-memory results through to WB and drives a forwarding path back to decode/execute.

Parameters:
ADDR_W, 32, width of mem_a_o; low ADDR_W bits of the byte address.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
read_i  in  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 = none
write_i  in  2  store type: 00 none, 01 SB, 10 SH, 11 SW
wd_i  in  5  destination register
wreg_i  in  1  register write enable
addr_i  in  32  load/store byte address
data_i  in  32  ALU result (non-mem) or store data
mem_a_o  out  ADDR_W  RAM byte address
mem_wr_o  out  1  RAM write strobe
mem_dout_o  out  8  RAM write byte
mem_din_i  in  8  RAM read byte; valid the cycle after its address is driven
stall_req_o  out  1  hold upstream stages; inputs stay stable while high
fwd_o  out  1  forwarding valid
fwd_addr_o  out  5  forwarded register
fwd_data_o  out  32  forwarded value
wb_wd_o  out  5  registered to WB
wb_wreg_o  out  1  registered to WB
wb_wdata_o  out  32  registered to WB

Behaviour:
- Byte counts: N = 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- If read_i and write_i are both nonzero, treat the instruction as a load; no write occurs.
- States: IDLE, LOAD, STORE; 3-bit byte counter cnt.
- Reset: state IDLE, cnt 0, all wb_* 0. mem_wr_o, stall_req_o and fwd_o are forced 0 while rst is high, even mid-access. A partial store may remain in RAM; no further bytes are written.
- IDLE, no memory op:
  - stall_req_o 0.
  - WB register loads wd_i, wreg_i, data_i at the edge (1-cycle latency).
  - fwd_o = wreg_i && wd_i != 0, with fwd_data_o = data_i.
- IDLE, load:
  - mem_a_o = addr_i, stall_req_o 1, mem_wr_o 0.
  - WB loads a bubble (wreg 0, wd 0, wdata 0).
  - Next state LOAD, cnt = 1.
- LOAD with cnt = k:
  - Capture mem_din_i into byte k-1 of the assembly register.
  - If k < N: mem_a_o = addr_i + k, stall_req_o 1, cnt = k+1, WB loads a bubble.
  - If k == N: stall_req_o 0. The extended value is formed combinationally from the captured bytes plus the current mem_din_i. fwd_o = wreg_i && wd_i != 0 with fwd_data_o = that value. WB loads wd_i, wreg_i, value. Next state IDLE.
  - Inputs are ignored in LOAD apart from the held instruction.
- Load latency: stall_req_o is high for N cycles; the instruction spends N+1 cycles in the stage.
- Extension:
  - LB: sign from bit 7. LH: sign from bit 15.
  - LBU/LHU: zero-extend.
  - LW: 4 bytes little-endian (byte0 = bits 7:0).
- IDLE, store:
  - mem_wr_o 1, mem_a_o = addr_i, mem_dout_o = data_i[7:0].
  - If N == 1: stall_req_o 0, WB loads a bubble, stay IDLE.
  - Else: stall_req_o 1, next state STORE, cnt = 1.
- STORE with cnt = k:
  - mem_wr_o 1, mem_a_o = addr_i + k, mem_dout_o = data_i byte k.
  - stall_req_o = (k < N-1).
  - At k == N-1, return to IDLE. WB always loads a bubble.
  - Stores write N cycles and stall N-1 cycles.
- Address increment wraps modulo 2^32; no alignment check.
- Outside active store cycles: mem_wr_o 0, mem_dout_o 0, mem_a_o 0 in IDLE without a memory op.
- fwd_o is 0 whenever stall_req_o is 1 and on all store cycles.
- Back-to-back: a new instruction is accepted the cycle after a load completes, or on the cycle after the last store byte. There are no idle gap cycles.

Test Plan:
- LW addr 0x100, RAM bytes 0x78,0x56,0x34,0x12, wd 5 -> stall_req_o high 4 cycles; fwd_data_o 0x12345678 on cycle 5; wb_wdata_o 0x12345678, wb_wd_o 5 the cycle after.
- LB addr 0x20 byte 0x80 -> stall 1 cycle, wdata 0xFFFFFF80; LBU same byte -> 0x00000080; LH bytes 0x34,0x92 -> 0xFFFF9234.
- SH addr 0x40, data_i 0xAABBCCDD -> mem_wr_o 2 cycles: (0x40,0xDD) then (0x41,0xCC); stall 1 cycle; wb_wreg_o 0.
- Pass-through: read_i 0, write_i 0, wreg_i 1, wd 3, data_i 7 -> no stall; fwd_o 1 with data 7 same cycle; wb_wdata_o 7 next cycle. Same with wd 0 -> fwd_o 0.
- rst asserted in the 2nd cycle of SW -> mem_wr_o 0 that cycle; next cycle IDLE, stall_req_o 0, wb_* 0.
- SB 0x55 to 0x10 immediately followed by LBU 0x10 -> store in 1 cycle, no gap; load returns 0x00000055.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline memory stage: byte-serial loads/stores over a synchronous byte RAM,
// load extension, WB register and a forwarding path back to decode/execute.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        read_i,
  input  logic [1:0]        write_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i,
  output logic              stall_req_o,
  output logic              fwd_o,
  output logic [4:0]        fwd_addr_o,
  output logic [31:0]       fwd_data_o,
  output logic [4:0]        wb_wd_o,
  output logic              wb_wreg_o,
  output logic [31:0]       wb_wdata_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  localparam logic [2:0] RD_LB  = 3'd1;
  localparam logic [2:0] RD_LH  = 3'd2;
  localparam logic [2:0] RD_LW  = 3'd3;
  localparam logic [2:0] RD_LBU = 3'd4;
  localparam logic [2:0] RD_LHU = 3'd5;

  function automatic logic [2:0] load_size(input logic [2:0] rd);
    case (rd)
      RD_LB, RD_LBU: load_size = 3'd1;
      RD_LH, RD_LHU: load_size = 3'd2;
      RD_LW:         load_size = 3'd4;
      default:       load_size = 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] store_size(input logic [1:0] wr);
    case (wr)
      2'd1:    store_size = 3'd1;
      2'd2:    store_size = 3'd2;
      2'd3:    store_size = 3'd4;
      default: store_size = 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] data_byte(input logic [31:0] d, input logic [2:0] k);
    case (k[1:0])
      2'd0:    data_byte = d[7:0];
      2'd1:    data_byte = d[15:8];
      2'd2:    data_byte = d[23:16];
      2'd3:    data_byte = d[31:24];
      default: data_byte = 8'd0;
    endcase
  endfunction

  // raw has unused upper bytes already zeroed, so only signed types need work
  function automatic logic [31:0] extend(input logic [2:0] rd, input logic [31:0] raw);
    case (rd)
      RD_LB:   extend = {{24{raw[7]}}, raw[7:0]};
      RD_LH:   extend = {{16{raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [23:0]  asm_q, asm_d;
  logic [4:0]   wb_wd_q, wb_wd_d;
  logic         wb_wreg_q, wb_wreg_d;
  logic [31:0]  wb_wdata_q, wb_wdata_d;

  logic         is_load_s, is_store_s;
  logic [2:0]   n_s;
  logic [31:0]  raw_s, load_val_s;
  logic [31:0]  mem_a_s;
  logic         mem_wr_s, stall_s, fwd_s;
  logic [7:0]   dout_s;
  logic [31:0]  fwd_data_s;

  // Instruction decode and final load value assembly
  always_comb begin
    is_load_s  = (read_i >= RD_LB) && (read_i <= RD_LHU);
    is_store_s = !is_load_s && (write_i != 2'd0);
    if (is_load_s) begin
      n_s = load_size(read_i);
    end else begin
      n_s = store_size(write_i);
    end
    case (n_s)
      3'd1:    raw_s = {24'd0, mem_din_i};
      3'd2:    raw_s = {16'd0, mem_din_i, asm_q[7:0]};
      default: raw_s = {mem_din_i, asm_q};
    endcase
    load_val_s = extend(read_i, raw_s);
  end

  // Next-state, RAM port, stall and forwarding control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    wb_wd_d    = 5'd0;
    wb_wreg_d  = 1'b0;
    wb_wdata_d = 32'd0;
    mem_a_s    = 32'd0;
    mem_wr_s   = 1'b0;
    dout_s     = 8'd0;
    stall_s    = 1'b0;
    fwd_s      = 1'b0;
    fwd_data_s = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (is_load_s) begin
          mem_a_s = addr_i;
          stall_s = 1'b1;
          state_d = S_LOAD;
          cnt_d   = 3'd1;
        end else if (is_store_s) begin
          mem_wr_s = 1'b1;
          mem_a_s  = addr_i;
          dout_s   = data_i[7:0];
          if (n_s == 3'd1) begin
            stall_s = 1'b0;
          end else begin
            stall_s = 1'b1;
            state_d = S_STORE;
            cnt_d   = 3'd1;
          end
        end else begin
          fwd_s      = wreg_i && (wd_i != 5'd0);
          fwd_data_s = data_i;
          wb_wd_d    = wd_i;
          wb_wreg_d  = wreg_i;
          wb_wdata_d = data_i;
        end
      end
      S_LOAD: begin
        case (cnt_q)
          3'd1:    asm_d[7:0]   = mem_din_i;
          3'd2:    asm_d[15:8]  = mem_din_i;
          3'd3:    asm_d[23:16] = mem_din_i;
          default: asm_d        = asm_q;
        endcase
        if (cnt_q < n_s) begin
          mem_a_s = addr_i + {29'd0, cnt_q};
          stall_s = 1'b1;
          cnt_d   = cnt_q + 3'd1;
        end else begin
          fwd_s      = wreg_i && (wd_i != 5'd0);
          fwd_data_s = load_val_s;
          wb_wd_d    = wd_i;
          wb_wreg_d  = wreg_i;
          wb_wdata_d = load_val_s;
          state_d    = S_IDLE;
          cnt_d      = 3'd0;
        end
      end
      S_STORE: begin
        mem_wr_s = 1'b1;
        mem_a_s  = addr_i + {29'd0, cnt_q};
        dout_s   = data_byte(data_i, cnt_q);
        stall_s  = (cnt_q < (n_s - 3'd1));
        if (cnt_q >= (n_s - 3'd1)) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, byte counter, load assembly and WB registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      asm_q      <= 24'd0;
      wb_wd_q    <= 5'd0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  // Reset kills any in-flight write, stall or forward immediately
  assign mem_a_o     = mem_a_s[ADDR_W-1:0];
  assign mem_wr_o    = mem_wr_s & ~rst;
  assign mem_dout_o  = dout_s;
  assign stall_req_o = stall_s & ~rst;
  assign fwd_o       = fwd_s & ~rst;
  assign fwd_addr_o  = wd_i;
  assign fwd_data_o  = fwd_data_s;
  assign wb_wd_o     = wb_wd_q;
  assign wb_wreg_o   = wb_wreg_q;
  assign wb_wdata_o  = wb_wdata_q;

endmodule
